mips_dmem: RTL and testbench

MIPS_DMEM -- requirements
Module: mips_dmem

---
 rtl/mips_pkg.sv | 26 ++
 rtl/mips_out_fifo.sv | 54 +++++
 rtl/mips_dmem.sv | 112 +++++++++++
 tb/tb_mips_dmem.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared data width, MMIO address map and STATUS layout for the MIPS data memory
package mips_pkg;

  localparam int DATA_MEM_WIDTH = 32;

  localparam logic [DATA_MEM_WIDTH-1:0] ADDR_OUT_DATA = 32'hFFFF_FF00;
  localparam logic [DATA_MEM_WIDTH-1:0] ADDR_STATUS   = 32'hFFFF_FF04;
  localparam logic [DATA_MEM_WIDTH-1:0] ADDR_CYCLE    = 32'hFFFF_FF08;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 4;
  localparam int ST_ERR       = 8;
  localparam int ST_OVERFLOW  = 9;
  localparam int ST_CLEAR     = 8;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_OUT,
    SEL_STATUS,
    SEL_CYCLE,
    SEL_BAD
  } dmem_sel_e;

endpackage

// File: rtl/mips_out_fifo.sv
// rtl/mips_out_fifo.sv - output word FIFO with push/full, pop/empty and occupancy count
module mips_out_fifo import mips_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_MEM_WIDTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Full is judged on the registered count, so a same-cycle pop never makes room for a push.
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/mips_dmem.sv
// rtl/mips_dmem.sv - MIPS data memory: word RAM plus OUT_DATA FIFO, STATUS and CYCLE MMIO registers
// CYCLE counter is present only when MIPS_DMEM_CYCLE_CNT_EN is defined.
module mips_dmem import mips_pkg::*; #(
  parameter int MEM_DEPTH  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      memwrite,
  input  logic [DATA_MEM_WIDTH-1:0] memaddr,
  input  logic [DATA_MEM_WIDTH-1:0] writedata,
  output logic [DATA_MEM_WIDTH-1:0] readdata,
  output logic                      out_valid,
  output logic [DATA_MEM_WIDTH-1:0] out_data,
  input  logic                      out_ready,
  output logic                      err
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_MEM_WIDTH-1:0] r_ram [MEM_DEPTH];
  logic                      r_err;
  logic                      r_overflow;
  dmem_sel_e                 w_sel;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_push_req;
  logic                      w_clear;
  logic [CW-1:0]             w_count;
  logic [DATA_MEM_WIDTH-1:0] w_status;
  logic [DATA_MEM_WIDTH-1:0] w_cycle;

  always_comb begin
    w_sel = SEL_BAD;
    if (memaddr[1:0] == 2'b00) begin
      if (memaddr[DATA_MEM_WIDTH-1:AW+2] == '0) w_sel = SEL_RAM;
      else if (memaddr == ADDR_OUT_DATA)        w_sel = SEL_OUT;
      else if (memaddr == ADDR_STATUS)          w_sel = SEL_STATUS;
      else if (memaddr == ADDR_CYCLE)           w_sel = SEL_CYCLE;
    end
  end

  assign w_push_req = memwrite && (w_sel == SEL_OUT);
  assign w_clear    = memwrite && (w_sel == SEL_STATUS) && writedata[ST_CLEAR];

  mips_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_MEM_WIDTH),
    .CW    (CW)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_req),
    .i_data  (writedata),
    .o_full  (w_full),
    .i_pop   (out_ready),
    .o_empty (w_empty),
    .o_data  (out_data),
    .o_count (w_count)
  );

  assign out_valid = !w_empty;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (!rst && memwrite && (w_sel == SEL_RAM)) r_ram[memaddr[AW+1:2]] <= writedata;
  end

  // A new error or overflow in the same cycle as a clear wins, so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_err      <= (w_sel == SEL_BAD) || (r_err && !w_clear);
      r_overflow <= (w_push_req && w_full) || (r_overflow && !w_clear);
    end
  end

`ifdef MIPS_DMEM_CYCLE_CNT_EN
  logic [DATA_MEM_WIDTH-1:0] r_cycle;

  always_ff @(posedge clk) begin
    if (rst)                                 r_cycle <= '0;
    else if (memwrite && (w_sel == SEL_CYCLE)) r_cycle <= writedata;
    else                                     r_cycle <= r_cycle + 1'b1;
  end

  assign w_cycle = r_cycle;
`else
  assign w_cycle = '0;
`endif

  always_comb begin
    w_status = '0;
    w_status[ST_FULL]                         = w_full;
    w_status[ST_EMPTY]                        = w_empty;
    w_status[ST_COUNT_LSB +: ST_COUNT_W]      = ST_COUNT_W'(w_count);
    w_status[ST_ERR]                          = r_err;
    w_status[ST_OVERFLOW]                     = r_overflow;
  end

  always_comb begin
    case (w_sel)
      SEL_RAM:    readdata = r_ram[memaddr[AW+1:2]];
      SEL_STATUS: readdata = w_status;
      SEL_CYCLE:  readdata = w_cycle;
      default:    readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_dmem.sv
// tb/tb_mips_dmem.sv - directed and randomized self-checking bench for mips_dmem with a behavioural model
module tb_mips_dmem;
  localparam int MEM_DEPTH  = 256;
  localparam int FIFO_DEPTH = 4;
  localparam logic [31:0] A_OUT    = 32'hFFFF_FF00;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FF04;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF08;
`ifdef MIPS_DMEM_CYCLE_CNT_EN
  localparam bit CYCLE_EN = 1'b1;
`else
  localparam bit CYCLE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        err;

  mips_dmem #(
    .MEM_DEPTH  (MEM_DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memwrite  (memwrite),
    .memaddr   (memaddr),
    .writedata (writedata),
    .readdata  (readdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] m_ram [MEM_DEPTH];
  bit          m_known [MEM_DEPTH];
  logic [31:0] m_q [$];
  bit          m_err;
  bit          m_ovf;
  logic [31:0] m_cycle;

  logic [31:0] s_rd;
  logic [31:0] s_out;
  logic        s_valid;
  logic        s_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_ram(input logic [31:0] a);
    return (a < 32'(MEM_DEPTH * 4));
  endfunction

  function automatic bit m_is_bad(input logic [31:0] a);
    if (a % 4 != 0) return 1'b1;
    if (in_ram(a))  return 1'b0;
    return !(a == A_OUT || a == A_STATUS || a == A_CYCLE);
  endfunction

  function automatic logic [31:0] m_status();
    int          n;
    logic [31:0] s;
    n = m_q.size();
    s = 32'(n * 16);
    if (n == FIFO_DEPTH) s = s + 1;
    if (n == 0)          s = s + 2;
    if (m_err)           s = s + 256;
    if (m_ovf)           s = s + 512;
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (m_is_bad(a))   return 32'h0;
    if (in_ram(a))     return m_ram[int'(a >> 2)];
    if (a == A_STATUS) return m_status();
    if (a == A_CYCLE)  return CYCLE_EN ? m_cycle : 32'h0;
    return 32'h0;
  endfunction

  task automatic model_step(input bit r, input bit we, input logic [31:0] a,
                            input logic [31:0] d, input bit rdy);
    bit bad;
    bit clr;
    bit push;
    int n;
    if (r) begin
      m_q.delete();
      m_err   = 1'b0;
      m_ovf   = 1'b0;
      m_cycle = 32'h0;
    end else begin
      bad  = m_is_bad(a);
      clr  = we && (a == A_STATUS) && d[8];
      push = we && (a == A_OUT);
      n    = m_q.size();
      m_err = bad || (m_err && !clr);
      m_ovf = (push && n == FIFO_DEPTH) || (m_ovf && !clr);
      if (n > 0 && rdy) void'(m_q.pop_front());
      if (push && n < FIFO_DEPTH) m_q.push_back(d);
      if (we && !bad && in_ram(a)) begin
        m_ram[int'(a >> 2)]   = d;
        m_known[int'(a >> 2)] = 1'b1;
      end
      if (we && a == A_CYCLE) m_cycle = d;
      else                    m_cycle = m_cycle + 32'h1;
    end
  endtask

  // One clock: drive, sample mid-cycle against the model, then advance the model at the edge.
  task automatic cycle(input bit r, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input bit rdy);
    bit known;
    rst = r; memwrite = we; memaddr = a; writedata = d; out_ready = rdy;
    @(negedge clk);
    s_rd = readdata; s_valid = out_valid; s_out = out_data; s_err = err;
    check("valid", 32'(s_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("out_data", s_out, m_q[0]);
    check("err", 32'(s_err), 32'(m_err));
    known = 1'b1;
    if (!m_is_bad(a) && in_ram(a)) known = m_known[int'(a >> 2)];
    if (known) check("readdata", s_rd, m_read(a));
    @(posedge clk);
    model_step(r, we, a, d, rdy);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    bit          we;
    bit          r;
    for (int i = 0; i < MEM_DEPTH; i++) m_known[i] = 1'b0;
    rst = 1'b1; memwrite = 1'b0; memaddr = 32'h0; writedata = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_q.delete(); m_err = 1'b0; m_ovf = 1'b0; m_cycle = 32'h0;

    cycle(0, 0, A_STATUS, 0, 0);
    check("rst_status", s_rd, 32'h0000_0002);
    check("rst_valid", 32'(s_valid), 32'h0);
    check("rst_err", 32'(s_err), 32'h0);

    cycle(0, 1, 32'h10, 32'hDEAD_BEEF, 0);
    cycle(0, 0, 32'h10, 0, 0);
    check("ram_rd", s_rd, 32'hDEAD_BEEF);
    check("ram_err", 32'(s_err), 32'h0);

    for (int i = 1; i <= 5; i++) cycle(0, 1, A_OUT, 32'(i), 0);
    cycle(0, 0, A_STATUS, 0, 0);
    check("ovf_status", s_rd, 32'h0000_0241);
    cycle(0, 0, A_OUT, 0, 0);
    check("out_rd_zero", s_rd, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 32'h10, 0, 1);
      check("drain", s_out, 32'(i));
    end
    cycle(0, 1, A_STATUS, 32'h100, 0);
    cycle(0, 0, A_STATUS, 0, 0);
    check("ovf_clear", s_rd, 32'h0000_0002);

    cycle(0, 1, A_OUT, 32'h11, 0);
    cycle(0, 1, A_OUT, 32'h22, 0);
    cycle(0, 1, A_OUT, 32'h33, 1);
    check("pp_head", s_out, 32'h11);
    cycle(0, 0, A_STATUS, 0, 0);
    check("pp_count", s_rd, 32'h0000_0020);
    cycle(0, 0, 32'h10, 0, 1);
    check("pp_order1", s_out, 32'h22);
    cycle(0, 0, 32'h10, 0, 1);
    check("pp_order2", s_out, 32'h33);
    cycle(0, 0, 32'h10, 0, 0);
    check("pp_empty", 32'(s_valid), 32'h0);

    cycle(0, 0, 32'h11, 0, 0);
    check("misal_rd", s_rd, 32'h0);
    cycle(0, 0, 32'h10, 0, 0);
    check("misal_err", 32'(s_err), 32'h1);
    cycle(0, 1, A_STATUS, 32'h100, 0);
    cycle(0, 0, 32'h10, 0, 0);
    check("err_clear", 32'(s_err), 32'h0);
    cycle(0, 0, 32'h0000_2000, 0, 0);
    check("unmap_rd", s_rd, 32'h0);
    cycle(0, 1, A_STATUS, 32'h100, 0);
    check("unmap_err", 32'(s_err), 32'h1);

    cycle(0, 1, A_CYCLE, 32'hFFFF_FFFE, 0);
    cycle(0, 0, A_CYCLE, 0, 0);
    check("cyc0", s_rd, CYCLE_EN ? 32'hFFFF_FFFE : 32'h0);
    cycle(0, 0, A_CYCLE, 0, 0);
    check("cyc1", s_rd, CYCLE_EN ? 32'hFFFF_FFFF : 32'h0);
    cycle(0, 0, A_CYCLE, 0, 0);
    check("cyc2", s_rd, 32'h0);
    check("cyc_err", 32'(s_err), 32'h0);

    cycle(0, 1, A_OUT, 32'h7, 0);
    cycle(0, 1, A_OUT, 32'h8, 0);
    cycle(0, 1, A_OUT, 32'h9, 0);
    cycle(1, 1, A_OUT, 32'hAA, 1);
    cycle(0, 0, A_STATUS, 0, 0);
    check("rst_fifo_valid", 32'(s_valid), 32'h0);
    check("rst_fifo_status", s_rd, 32'h0000_0002);
    cycle(0, 0, 32'h10, 0, 0);
    check("rst_ram_kept", s_rd, 32'hDEAD_BEEF);

    for (int n = 0; n < 3000; n++) begin
      we = 1'b0;
      d  = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: begin a = 32'($urandom_range(0, 15)) << 2; we = $urandom_range(0, 1) == 1; end
        3, 4:    begin a = A_OUT; we = $urandom_range(0, 2) != 0; end
        5:       begin a = A_STATUS; we = $urandom_range(0, 3) == 0; end
        6:       begin a = A_CYCLE; we = $urandom_range(0, 3) == 0; end
        7:       begin a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3)); we = $urandom_range(0, 1) == 1; end
        8:       begin a = ($urandom_range(0, 1) == 1) ? A_OUT + 32'hC : 32'h400 + (32'($urandom_range(0, 255)) << 2); we = $urandom_range(0, 1) == 1; end
        default: a = 32'($urandom_range(0, MEM_DEPTH - 1)) << 2;
      endcase
      r = $urandom_range(0, 99) == 0;
      cycle(r, we, a, d, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
